counter_job_arbiter: RTL

- Controller that shares one universal_counter instance between two requesters.
- Each requester submits a counting job: start value, direction, tick count. The block arbitrates round-robin, then sequences the counter's load/incr/pause controls to run the job.
- When the job finishes, it reports completion and the final counter value.
- Sits between client logic and the universal_counter (data, load, incr, pause, clock → counter).

---
 rtl/counter_job_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/counter_job_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_job_arbiter
// Description : Shares one universal_counter between two requesters. Each
//               client submits a counting job (start value, direction, tick
//               count). Requests are arbitrated round-robin in IDLE, then
//               the counter's load/incr/pause controls are sequenced to run
//               the job. Completion is reported with a one-cycle done pulse
//               and the final counter value.
// Revision    : 1.0 - initial release
//
// Optional build macro:
//   COUNTER_CHECK_EN - when defined, the expected result (data +/- len) is
//                      computed in LOAD and compared against the counter in
//                      DONE; any mismatch sets the sticky err flag. When
//                      undefined, err is tied low.
//
// Ports:
//   clock, reset_n           - system clock (rising edge), async active-low reset
//   req0/req1                - job requests, held until the matching gnt is seen
//   data0/data1              - job start values
//   dir0/dir1                - 1 = count up, 0 = count down
//   len0/len1                - number of count ticks
//   hold0/hold1              - pause request, honoured only from the owner in RUN
//   ctr_value                - current value from the universal_counter
//   gnt0/gnt1                - grant (one-hot or zero), high LOAD..DONE
//   done0/done1              - one-cycle completion pulse
//   busy                     - high whenever a job is in progress
//   final_value              - counter value captured in DONE
//   ctr_data/load/incr/pause - controls driven to the universal_counter
//   err                      - sticky result-mismatch flag
// ============================================================================
module counter_job_arbiter #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic             dir0,
  input  logic             dir1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             hold0,
  input  logic             hold1,
  input  logic [WIDTH-1:0] ctr_value,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] final_value,
  output logic [WIDTH-1:0] ctr_data,
  output logic             ctr_load,
  output logic             ctr_incr,
  output logic             ctr_pause,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;      // client owning the current job
  logic             r_last;       // client granted most recently
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_final;

  logic             w_any_req;
  logic             w_pick;
  logic             w_hold;

  assign w_any_req = req0 | req1;
  // On a tie the client not granted last wins; otherwise the sole requester.
  assign w_pick    = (req0 && req1) ? ~r_last : req1;
  assign w_hold    = r_owner ? hold1 : hold0;

  // --------------------------------------------------------------------------
  // Next-state and counter-control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    ctr_load  = 1'b0;
    ctr_pause = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_next = S_LOAD;
      end
      S_LOAD: begin
        ctr_load  = 1'b1;
        ctr_pause = 1'b0;
        w_next    = (r_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        ctr_pause = w_hold;
        // The final tick is applied by the counter in this same cycle.
        if (!w_hold && (r_remaining == LEN_W'(1))) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and job registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_data      <= '0;
      r_dir       <= 1'b1;
      r_len       <= '0;
      r_remaining <= '0;
      r_final     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick;
            r_data  <= w_pick ? data1 : data0;
            r_dir   <= w_pick ? dir1  : dir0;
            r_len   <= w_pick ? len1  : len0;
          end
        end
        S_LOAD: r_remaining <= r_len;
        S_RUN: begin
          if (!w_hold) r_remaining <= r_remaining - LEN_W'(1);
        end
        S_DONE: begin
          r_final <= ctr_value;
          r_last  <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy        = (r_state != S_IDLE);
  assign gnt0        = busy & ~r_owner;
  assign gnt1        = busy &  r_owner;
  assign done0       = (r_state == S_DONE) & ~r_owner;
  assign done1       = (r_state == S_DONE) &  r_owner;
  assign final_value = r_final;
  assign ctr_data    = r_data;
  assign ctr_incr    = r_dir;

`ifdef COUNTER_CHECK_EN
  logic [WIDTH-1:0] r_expected;
  logic             r_err;
  logic [WIDTH-1:0] w_len_ext;

  assign w_len_ext = WIDTH'(r_len);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_expected <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_LOAD)
        r_expected <= r_dir ? (r_data + w_len_ext) : (r_data - w_len_ext);
      if ((r_state == S_DONE) && (ctr_value != r_expected))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
